// File: rtl/measure_rx_checker.sv
// GMII receive frame checker: FCS check, magic/timestamp capture, latency publish, counters.
// Define MEASURE_RX_MINMAX_EN to build the lat_min/lat_max trackers.
module measure_rx_checker #(
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned MIN_LEN = 64,
    parameter logic [31:0] MAGIC   = 32'hdeadbeef
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx_dv,
    input  logic [7:0]  rx_data,
    input  logic [31:0] timer,
    output logic        lat_valid,
    output logic [31:0] latency,
    output logic [11:0] frame_len,
    output logic [15:0] good_cnt,
    output logic [15:0] err_cnt,
    output logic        busy,
    output logic [31:0] lat_min,
    output logic [31:0] lat_max
);

    localparam logic [11:0] MaxLen     = 12'(MAX_LEN);
    localparam logic [11:0] MinLen     = 12'(MIN_LEN);
    localparam logic [31:0] CrcResidue = 32'hdebb20e3;
    localparam logic [11:0] OffMagic   = 12'h02a;
    localparam logic [11:0] OffTs      = 12'h02e;
    localparam logic [11:0] OffCalc    = 12'h032;

    typedef enum logic [1:0] {StIdle, StPre, StBody, StDrop} state_e;

    state_e      state_q;
    logic [11:0] byte_cnt_q;
    logic [31:0] crc_q;
    logic [31:0] magic_q;
    logic [31:0] rx_ts_q;
    logic [31:0] cand_q;
    logic        frame_end;
    logic        frame_ok;
    logic        publish;

    // Reflected CRC-32 update, one byte LSB first.
    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

    assign frame_end = (state_q == StBody) && !rx_dv;
    assign frame_ok  = (byte_cnt_q >= MinLen) && (crc_q == CrcResidue);
    assign publish   = frame_end && frame_ok && (magic_q == MAGIC) && (byte_cnt_q > OffCalc);
    assign busy      = (state_q != StIdle);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            crc_q      <= 32'hffffffff;
            magic_q    <= '0;
            rx_ts_q    <= '0;
            cand_q     <= '0;
            lat_valid  <= 1'b0;
            latency    <= '0;
            frame_len  <= '0;
            good_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            lat_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rx_dv) begin
                        state_q <= (rx_data == 8'h55) ? StPre : StDrop;
                    end
                end
                StPre: begin
                    if (!rx_dv) begin
                        state_q <= StIdle;
                    end else if (rx_data == 8'hd5) begin
                        state_q    <= StBody;
                        byte_cnt_q <= '0;
                        crc_q      <= 32'hffffffff;
                        magic_q    <= '0;
                        rx_ts_q    <= '0;
                    end else if (rx_data != 8'h55) begin
                        state_q <= StDrop;
                        err_cnt <= sat_inc(err_cnt);
                    end
                end
                StBody: begin
                    if (frame_end) begin
                        state_q   <= StIdle;
                        frame_len <= byte_cnt_q;
                        if (!frame_ok) begin
                            err_cnt <= sat_inc(err_cnt);
                        end else if (publish) begin
                            latency   <= cand_q;
                            lat_valid <= 1'b1;
                            good_cnt  <= sat_inc(good_cnt);
                        end
                    end else if (byte_cnt_q == MaxLen) begin
                        state_q   <= StDrop;
                        err_cnt   <= sat_inc(err_cnt);
                        frame_len <= MaxLen;
                    end else begin
                        crc_q      <= crc_step(crc_q, rx_data);
                        byte_cnt_q <= byte_cnt_q + 12'd1;
                        if (byte_cnt_q >= OffMagic && byte_cnt_q < OffTs) begin
                            magic_q <= {magic_q[23:0], rx_data};
                        end
                        if (byte_cnt_q >= OffTs && byte_cnt_q < OffCalc) begin
                            rx_ts_q <= {rx_ts_q[23:0], rx_data};
                        end
                        // Unsigned subtraction wraps correctly across a timer rollover.
                        if (byte_cnt_q == OffCalc) begin
                            cand_q <= timer - rx_ts_q;
                        end
                    end
                end
                StDrop: begin
                    if (!rx_dv) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef MEASURE_RX_MINMAX_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_min <= 32'hffffffff;
            lat_max <= '0;
        end else if (publish) begin
            if (cand_q < lat_min) lat_min <= cand_q;
            if (cand_q > lat_max) lat_max <= cand_q;
        end
    end
`else
    assign lat_min = '0;
    assign lat_max = '0;
`endif

endmodule

// File: tb/tb_measure_rx_checker.sv
// Bench for measure_rx_checker: directed plan frames plus random frames against a frame-level model.
module tb_measure_rx_checker;

    typedef logic [7:0] byte_t;

    localparam int unsigned MAX_LEN = 1518;
    localparam int unsigned MIN_LEN = 64;
    localparam logic [31:0] MAGIC   = 32'hdeadbeef;
`ifdef MEASURE_RX_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        rx_dv;
    logic [7:0]  rx_data;
    logic [31:0] timer;
    logic        lat_valid;
    logic [31:0] latency;
    logic [11:0] frame_len;
    logic [15:0] good_cnt;
    logic [15:0] err_cnt;
    logic        busy;
    logic [31:0] lat_min;
    logic [31:0] lat_max;

    measure_rx_checker #(
        .MAX_LEN(MAX_LEN),
        .MIN_LEN(MIN_LEN),
        .MAGIC  (MAGIC)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rx_dv    (rx_dv),
        .rx_data  (rx_data),
        .timer    (timer),
        .lat_valid(lat_valid),
        .latency  (latency),
        .frame_len(frame_len),
        .good_cnt (good_cnt),
        .err_cnt  (err_cnt),
        .busy     (busy),
        .lat_min  (lat_min),
        .lat_max  (lat_max)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    byte_t       body[$];
    logic [15:0] exp_good;
    logic [15:0] exp_err;
    logic [31:0] exp_lat;
    logic [11:0] exp_len;
    logic [31:0] exp_min;
    logic [31:0] exp_max;
    int          exp_pulses = 0;

    always @(negedge clock) if (lat_valid === 1'b1) pulses++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

    // Frame check sequence as transmitted: complement of the bitwise reflected CRC.
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hffffffff;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ body[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hedb88320;
            end
        end
        return ~c;
    endfunction

    task automatic model_reset();
        exp_good = '0;
        exp_err  = '0;
        exp_lat  = '0;
        exp_len  = '0;
        exp_min  = MM ? 32'hffffffff : 32'h0;
        exp_max  = '0;
    endtask

    task automatic model_frame(input logic [31:0] t32);
        int          n;
        logic [31:0] fcs_rx;
        logic [31:0] m;
        logic [31:0] ts;
        logic [31:0] lat;
        bit          crc_ok;
        n = body.size();
        if (n > int'(MAX_LEN)) begin
            exp_len = 12'(MAX_LEN);
            exp_err = sat(exp_err);
            return;
        end
        exp_len = 12'(n);
        crc_ok  = 1'b0;
        if (n >= 4) begin
            fcs_rx = {body[n-1], body[n-2], body[n-3], body[n-4]};
            crc_ok = (fcs_of(n - 4) == fcs_rx);
        end
        if (n < int'(MIN_LEN) || !crc_ok) begin
            exp_err = sat(exp_err);
        end else if (n > 'h32) begin
            m  = {body['h2a], body['h2b], body['h2c], body['h2d]};
            ts = {body['h2e], body['h2f], body['h30], body['h31]};
            if (m == MAGIC) begin
                lat      = t32 - ts;
                exp_lat  = lat;
                exp_good = sat(exp_good);
                exp_pulses++;
                if (MM) begin
                    if (lat < exp_min) exp_min = lat;
                    if (lat > exp_max) exp_max = lat;
                end
            end
        end
    endtask

    task automatic build_body(input int len, input bit magic_ok, input logic [31:0] ts,
                              input bit corrupt);
        logic [31:0] m;
        logic [31:0] f;
        int          n;
        int          idx;
        n = len - 4;
        body.delete();
        for (int i = 0; i < n; i++) body.push_back(byte_t'($urandom));
        m = magic_ok ? MAGIC : (MAGIC ^ 32'h0000_0100);
        if (n >= 'h32) begin
            for (int k = 0; k < 4; k++) begin
                body['h2a + k] = m[31 - 8*k -: 8];
                body['h2e + k] = ts[31 - 8*k -: 8];
            end
        end
        f = fcs_of(n);
        for (int k = 0; k < 4; k++) body.push_back(f[8*k +: 8]);
        if (corrupt) begin
            idx       = int'($urandom_range(len - 1));
            body[idx] = body[idx] ^ byte_t'(1 << $urandom_range(7));
        end
    endtask

    task automatic drive(input byte_t d, input logic [31:0] t);
        @(negedge clock);
        rx_dv   = 1'b1;
        rx_data = d;
        timer   = t;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            rx_dv   = 1'b0;
            rx_data = byte_t'($urandom);
            timer   = $urandom;
        end
    endtask

    task automatic send_frame(input int npre, input logic [31:0] t32);
        for (int i = 0; i < npre; i++) drive(8'h55, $urandom);
        drive(8'hd5, $urandom);
        for (int i = 0; i < body.size(); i++) drive(body[i], (i == 'h32) ? t32 : $urandom);
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".len"},     32'(frame_len), 32'(exp_len));
        check_eq({tag, ".good"},    32'(good_cnt),  32'(exp_good));
        check_eq({tag, ".err"},     32'(err_cnt),   32'(exp_err));
        check_eq({tag, ".latency"}, latency,        exp_lat);
        check_eq({tag, ".pulses"},  32'(pulses),    32'(exp_pulses));
        check_eq({tag, ".valid"},   32'(lat_valid), 32'h0);
        check_eq({tag, ".busy"},    32'(busy),      32'h0);
        check_eq({tag, ".min"},     lat_min,        exp_min);
        check_eq({tag, ".max"},     lat_max,        exp_max);
    endtask

    task automatic run_frame(input string tag, input int len, input bit mok,
                             input logic [31:0] ts, input logic [31:0] t, input bit cor);
        build_body(len, mok, ts, cor);
        model_frame(t);
        send_frame($urandom_range(1, 7), t);
        idle(3);
        check_all(tag);
    endtask

    initial begin
        int          kind;
        int          p0;
        logic [31:0] ts;
        logic [31:0] t;
        byte_t       bad;

        reset_n = 1'b0;
        rx_dv   = 1'b0;
        rx_data = '0;
        timer   = '0;
        model_reset();
        repeat (3) @(negedge clock);
        check_all("reset");
        reset_n = 1'b1;
        idle(2);

        // Measurement frame from the sender
        p0 = pulses;
        build_body(64, 1'b1, 32'h0000_1000, 1'b0);
        model_frame(32'h0000_1234);
        send_frame(7, 32'h0000_1234);
        idle(3);
        check_all("arp");
        check_eq("arp.lat_abs", latency, 32'h234);
        check_eq("arp.good_abs", 32'(good_cnt), 32'd1);
        check_eq("arp.len_abs", 32'(frame_len), 32'd64);
        check_eq("arp.one_pulse", 32'(pulses - p0), 32'd1);

        // Same frame with one payload bit flipped
        build_body(64, 1'b1, 32'h0000_1000, 1'b0);
        body[20] = body[20] ^ 8'h04;
        model_frame(32'h0000_1234);
        send_frame(7, 32'h0000_1234);
        idle(3);
        check_all("crcbad");
        check_eq("crcbad.err_abs", 32'(err_cnt), 32'd1);
        check_eq("crcbad.lat_abs", latency, 32'h234);

        run_frame("wrap", 64, 1'b1, 32'hffff_fff0, 32'h0000_0010, 1'b0);
        check_eq("wrap.lat_abs", latency, 32'h20);

        run_frame("runt40", 40, 1'b1, 32'h0, 32'h0, 1'b0);
        check_eq("runt40.len_abs", 32'(frame_len), 32'd40);
        run_frame("runt63", 63, 1'b1, $urandom, $urandom, 1'b0);
        run_frame("max1518", 1518, 1'b1, $urandom, $urandom, 1'b0);

        // Oversize bursts stay in drop until rx_dv falls
        foreach (body[i]) body[i] = body[i];
        build_body(1600, 1'b1, $urandom, 1'b0);
        model_frame(32'h0);
        send_frame(7, 32'h0);
        @(negedge clock);
        check_eq("over1600.busy_hi", 32'(busy), 32'h1);
        rx_dv = 1'b0;
        idle(2);
        check_all("over1600");
        check_eq("over1600.len_abs", 32'(frame_len), 32'd1518);
        run_frame("over1519", 1519, 1'b1, $urandom, $urandom, 1'b0);

        // Back-to-back good frames, then a broken preamble
        model_reset();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        build_body(64, 1'b1, 32'h100, 1'b0);
        model_frame(32'h150);
        send_frame(7, 32'h150);
        idle(1);
        build_body(72, 1'b1, 32'h200, 1'b0);
        model_frame(32'h277);
        send_frame(7, 32'h277);
        idle(1);
        drive(8'h55, $urandom);
        drive(8'h55, $urandom);
        drive(8'haa, $urandom);
        for (int i = 0; i < 5; i++) drive(byte_t'($urandom), $urandom);
        exp_err = sat(exp_err);
        idle(3);
        check_all("b2b");
        check_eq("b2b.good_abs", 32'(good_cnt), 32'd2);
        check_eq("b2b.err_abs", 32'(err_cnt), 32'd1);

        // Reset in the middle of a third frame
        build_body(64, 1'b1, 32'h10, 1'b0);
        for (int i = 0; i < 7; i++) drive(8'h55, $urandom);
        drive(8'hd5, $urandom);
        for (int i = 0; i < 30; i++) drive(body[i], $urandom);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("rstmid");
        rx_dv = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        idle(2);
        check_all("rstmid_after");

        ts = $urandom;
        run_frame("mm300", 64, 1'b1, ts, ts + 32'h300, 1'b0);
        ts = $urandom;
        run_frame("mm100", 80, 1'b1, ts, ts + 32'h100, 1'b0);
        ts = $urandom;
        run_frame("mm200", 64, 1'b1, ts, ts + 32'h200, 1'b0);
        check_eq("mm.min_abs", lat_min, MM ? 32'h100 : 32'h0);
        check_eq("mm.max_abs", lat_max, MM ? 32'h300 : 32'h0);

        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(15));
            if (kind == 0) begin
                repeat ($urandom_range(1, 7)) drive(8'h55, $urandom);
                bad = byte_t'($urandom);
                if (bad == 8'h55 || bad == 8'hd5) bad = 8'h3c;
                drive(bad, $urandom);
                repeat ($urandom_range(0, 6)) drive(byte_t'($urandom), $urandom);
                exp_err = sat(exp_err);
                idle(3);
                check_all($sformatf("rnd%0d.pre", it));
            end else if (kind == 1) begin
                bad = byte_t'($urandom);
                if (bad == 8'h55) bad = 8'h12;
                drive(bad, $urandom);
                repeat ($urandom_range(1, 10)) drive(byte_t'($urandom), $urandom);
                idle(3);
                check_all($sformatf("rnd%0d.idle", it));
            end else begin
                run_frame($sformatf("rnd%0d", it), int'($urandom_range(50, 140)),
                          $urandom_range(3) != 0, $urandom, $urandom, $urandom_range(5) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/measure_rx_checker.md
Name: measure_rx_checker

Overview:
- GMII receive-side frame checker for the latency measurement path, on the PHY#2 receive side.
- Delineates frames on rx_dv/rx_data and verifies the Ethernet FCS.
- Extracts the 0xdeadbeef magic word and the 32-bit sender timestamp, then publishes a latency sample for each good measurement frame.
- Keeps saturating good/error frame counters for LED/7-seg display logic.

Parameters:
MAX_LEN, 1518, maximum accepted frame length in bytes (DA through FCS)
MIN_LEN, 64, minimum accepted frame length in bytes (DA through FCS)
MAGIC, 32'hdeadbeef, magic word expected at frame offsets 0x2A..0x2D

Ports:
clock  input  1  receive clock; all logic on its rising edge
reset_n  input  1  asynchronous, active-low reset
rx_dv  input  1  GMII receive data valid
rx_data  input  8  GMII receive data
timer  input  32  free-running local timestamp, same clock domain
lat_valid  output  1  one-cycle pulse: latency updated
latency  output  32  last published latency, in clock ticks
frame_len  output  12  byte length of the last completed frame (DA..FCS)
good_cnt  output  16  good measurement frames, saturating
err_cnt  output  16  CRC/runt/oversize/preamble errors, saturating
busy  output  1  high while state is not IDLE
lat_min  output  32  minimum latency (optional feature)
lat_max  output  32  maximum latency (optional feature)

Behaviour:
- Reset values (async on reset_n low): all outputs 0 (lat_min excepted, see Optional Feature); state IDLE; byte counter 0; CRC register 32'hFFFFFFFF.
- States:
  - IDLE: rx_dv=1 and rx_data=8'h55 -> PRE. rx_dv=1 with any other byte -> DROP.
  - PRE: 8'h55 stays in PRE; 8'hD5 -> BODY (byte count 0, CRC init); any other byte -> DROP, err_cnt+1; rx_dv=0 -> IDLE, no count.
  - BODY: each rx_dv=1 cycle feeds one byte; the byte counter indexes it (0 = first DA byte).
  - DROP: wait for rx_dv=0, then IDLE.
- CRC: IEEE 802.3 CRC-32, reflected/LSB-first, poly 0x04C11DB7, init 0xFFFFFFFF, computed over all BODY bytes including the FCS. Good iff the register equals 32'hDEBB20E3 at end of frame.
- Capture in BODY:
  - offsets 0x2A..0x2D -> magic register, MSB first;
  - offsets 0x2E..0x31 -> rx_ts register, MSB first;
  - at offset 0x32, candidate = timer - rx_ts, modulo 2^32 (wrap-around yields the correct unsigned difference).
- Oversize: byte count reaches MAX_LEN with rx_dv still 1 -> DROP, err_cnt+1, frame_len=MAX_LEN.
- End of frame: first cycle with rx_dv=0 in BODY; the next edge returns to IDLE.
  - frame_len = byte count.
  - len<MIN_LEN or CRC bad -> err_cnt+1.
  - Else, if magic==MAGIC and len>0x32: latency=candidate, lat_valid=1 for exactly one cycle (the cycle after rx_dv falls), good_cnt+1.
  - Else (good non-measurement frame): no counter change.
- Counters saturate at 16'hFFFF.
- rx_dv rising in the same cycle the end of the previous frame is processed: the new byte is evaluated from IDLE in that cycle (zero-gap back-to-back frames must be accepted).
- Reset mid-frame: immediate abort to IDLE; the partial frame is not counted.

Optional Feature:
- MEASURE_RX_MINMAX_EN defined:
  - lat_min resets to 32'hFFFFFFFF; lat_max resets to 0.
  - Both update on the same edge as lat_valid: lat_min=min(lat_min,latency_new), lat_max=max(lat_max,latency_new).
- Undefined: lat_min and lat_max are constant 0 and no comparators are built.

Test Plan:
- Sender-format ARP frame (7x55, D5, 64 bytes incl. valid FCS), ts=0x00001000, timer=0x00001234 at offset 0x32 -> latency=0x234, one lat_valid pulse, good_cnt=1, frame_len=64.
- Same frame with one payload bit flipped -> no lat_valid, err_cnt=1, latency unchanged.
- ts=0xFFFFFFF0, timer=0x00000010 at offset 0x32 -> latency=0x20.
- 40-byte frame with valid FCS -> err_cnt+1, frame_len=40; 1600-byte burst -> err_cnt+1, frame_len=1518, DROP until rx_dv low.
- Two good frames with 0 idle gap, then preamble 55,55,AA -> good_cnt=2, err_cnt=1; reset_n pulsed mid third frame -> all outputs 0, no count.
- With MEASURE_RX_MINMAX_EN, latencies 0x300, 0x100, 0x200 -> lat_min=0x100, lat_max=0x300; without the macro both read 0.
